// File: rtl/fir_pkg.sv
// Shared types and default sizing for the FIR tap-chain sequencer.
// Widths here are also used by the tap-register chain itself.
package fir_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    MAC,
    DONE
  } fir_state_e;

  localparam int TAPS  = 8;
  localparam int BITSX = 16;
  localparam int BITSC = 16;

  // Sum of Taps full-precision products never overflows this width.
  function automatic int acc_w(input int bx, input int bc, input int taps);
    return bx + bc + $clog2(taps);
  endfunction

  localparam int ACCW = acc_w(BITSX, BITSC, TAPS);

endpackage

// File: rtl/fir_mac.sv
// Signed multiply-accumulate with synchronous clear and enable.
// The product is sign-extended into the accumulator at full precision.
module fir_mac #(
  parameter int BitsA = 16,
  parameter int BitsB = 16,
  parameter int AccW  = 35
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [BitsA-1:0] a,
  input  logic signed [BitsB-1:0] b,
  output logic signed [AccW-1:0]  acc
);

  logic signed [BitsA+BitsB-1:0] prod;

  assign prod = a * b;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + AccW'(prod);
    end
  end

endmodule

// File: rtl/fir_ctrl.sv
// FIR tap-chain sequencer: sample handshake, shift/load strobes,
// tap sweep and MAC result handshake.
module fir_ctrl
  import fir_pkg::*;
#(
  parameter int Taps  = TAPS,
  parameter int BitsX = BITSX,
  parameter int BitsC = BITSC,
  parameter int AccW  = acc_w(BitsX, BitsC, Taps),
  parameter int SelW  = $clog2(Taps)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic        [BitsX-1:0] in_data,
  output logic                    in_ready,
  output logic        [BitsX-1:0] datta,
  output logic                    stm,
  output logic                    ldx,
  output logic        [SelW-1:0]  tap_sel,
  input  logic signed [BitsX-1:0] tap_x,
  input  logic signed [BitsC-1:0] coef,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [AccW-1:0]  y
);

  localparam logic [SelW-1:0] LAST = SelW'(Taps - 1);

  fir_state_e state;
  logic       clr;
  logic       en;

  assign clr = (state == LOAD);
  assign en  = (state == MAC);

  fir_mac #(
    .BitsA(BitsX),
    .BitsB(BitsC),
    .AccW (AccW)
  ) u_mac (
    .clk(clk),
    .rst(rst),
    .clr(clr),
    .en (en),
    .a  (tap_x),
    .b  (coef),
    .acc(y)
  );

  // Strobes default low every cycle so each lasts exactly one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      datta     <= '0;
      stm       <= 1'b0;
      ldx       <= 1'b0;
      tap_sel   <= '0;
      out_valid <= 1'b0;
    end else begin
      stm <= 1'b0;
      ldx <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            datta    <= in_data;
            in_ready <= 1'b0;
            stm      <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          ldx     <= 1'b1;
          tap_sel <= '0;
          state   <= LOAD;
        end
        LOAD: begin
          state <= MAC;
        end
        MAC: begin
          if (tap_sel == LAST) begin
            tap_sel   <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            tap_sel <= tap_sel + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_ctrl.sv
// Directed bench for fir_ctrl with a behavioural tap-register chain.
// Vector table covers impulse, mixed-sign and full-scale sequences.
module tb_fir_ctrl;

  localparam int TAPS = 8;
  localparam int BX   = 16;
  localparam int BC   = 16;
  localparam int AW   = 35;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic        [BX-1:0] in_data = '0;
  logic                 in_ready;
  logic        [BX-1:0] datta;
  logic                 stm;
  logic                 ldx;
  logic        [2:0]    tap_sel;
  logic signed [BX-1:0] tap_x;
  logic signed [BC-1:0] coef;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic signed [AW-1:0] y;

  fir_ctrl #(.Taps(TAPS), .BitsX(BX), .BitsC(BC)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .datta    (datta),
    .stm      (stm),
    .ldx      (ldx),
    .tap_sel  (tap_sel),
    .tap_x    (tap_x),
    .coef     (coef),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int nsent = 0;
  int stm_cnt = 0;
  int overlap = 0;
  bit cset = 1'b0;

  // Tap chain: shift on stm, copy to output stage on ldx.
  logic signed [BX-1:0] chain [TAPS];
  logic signed [BX-1:0] stage [TAPS];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        chain[i] <= '0;
        stage[i] <= '0;
      end
    end else begin
      if (stm) begin
        chain[0] <= datta;
        for (int i = 1; i < TAPS; i++) chain[i] <= chain[i-1];
      end
      if (ldx) begin
        for (int i = 0; i < TAPS; i++) stage[i] <= chain[i];
      end
      if (stm) stm_cnt <= stm_cnt + 1;
      if (stm && ldx) overlap <= overlap + 1;
    end
  end

  assign tap_x = stage[tap_sel];
  assign coef  = cset ? -16'sd32768 : BC'(32'(tap_sel) + 1);

  typedef struct {
    bit     rst_first;
    bit     cs;
    int     x;
    longint ey;
  } vec_t;

  vec_t vt [20];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
                     input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int x, input longint ey, input bit hold);
    out_ready = !hold;
    chk("in_ready_idle", {63'd0, in_ready}, 64'sd1);
    in_valid = 1'b1;
    in_data  = BX'(x);
    tick();
    nsent++;
    in_valid = 1'b0;
    in_data  = '0;
    chk("c1_stm", {63'd0, stm}, 64'sd1);
    chk("c1_ldx", {63'd0, ldx}, 64'sd0);
    chk("c1_in_ready", {63'd0, in_ready}, 64'sd0);
    chk("c1_datta", 64'($signed(datta)), 64'(x));
    tick();
    chk("c2_ldx", {63'd0, ldx}, 64'sd1);
    chk("c2_stm", {63'd0, stm}, 64'sd0);
    for (int c = 3; c <= 10; c++) begin
      tick();
      chk("mac_tap_sel", {61'd0, tap_sel}, 64'(c - 3));
      chk("mac_out_valid", {63'd0, out_valid}, 64'sd0);
    end
    tick();
    chk("c11_out_valid", {63'd0, out_valid}, 64'sd1);
    chk("c11_y", 64'(y), 64'(ey));
    if (!hold) begin
      tick();
      chk("post_out_valid", {63'd0, out_valid}, 64'sd0);
      chk("post_in_ready", {63'd0, in_ready}, 64'sd1);
    end
  endtask

  initial begin
    vt[0]  = '{1, 0,  1, 1};
    vt[1]  = '{0, 0,  0, 2};
    vt[2]  = '{0, 0,  0, 3};
    vt[3]  = '{0, 0,  0, 4};
    vt[4]  = '{0, 0,  0, 5};
    vt[5]  = '{0, 0,  0, 6};
    vt[6]  = '{0, 0,  0, 7};
    vt[7]  = '{0, 0,  0, 8};
    vt[8]  = '{0, 0,  0, 0};
    vt[9]  = '{1, 0,  3, 3};
    vt[10] = '{0, 0, -2, 4};
    vt[11] = '{0, 0,  5, 10};
    vt[12] = '{1, 1, -32768, 64'sd1073741824};
    vt[13] = '{0, 1, -32768, 64'sd2147483648};
    vt[14] = '{0, 1, -32768, 64'sd3221225472};
    vt[15] = '{0, 1, -32768, 64'sd4294967296};
    vt[16] = '{0, 1, -32768, 64'sd5368709120};
    vt[17] = '{0, 1, -32768, 64'sd6442450944};
    vt[18] = '{0, 1, -32768, 64'sd7516192768};
    vt[19] = '{0, 1, -32768, 64'sd8589934592};

    // Reset and idle
    do_reset();
    rst = 1'b1;
    tick();
    chk("rst_in_ready", {63'd0, in_ready}, 64'sd1);
    chk("rst_datta", {48'd0, datta}, 64'sd0);
    chk("rst_stm", {63'd0, stm}, 64'sd0);
    chk("rst_ldx", {63'd0, ldx}, 64'sd0);
    chk("rst_tap_sel", {61'd0, tap_sel}, 64'sd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("rst_y", 64'(y), 64'sd0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_in_ready", {63'd0, in_ready}, 64'sd1);
      chk("idle_stm", {63'd0, stm}, 64'sd0);
      chk("idle_ldx", {63'd0, ldx}, 64'sd0);
    end

    for (int i = 0; i < 20; i++) begin
      cset = vt[i].cs;
      if (vt[i].rst_first) do_reset();
      send(vt[i].x, vt[i].ey, 1'b0);
    end

    // Backpressure: DONE held, in_valid ignored
    cset = 1'b0;
    do_reset();
    send(7, 7, 1'b1);
    for (int i = 0; i < 20; i++) begin
      in_valid = i[0];
      in_data  = 16'd99;
      tick();
      chk("bp_out_valid", {63'd0, out_valid}, 64'sd1);
      chk("bp_y", 64'(y), 64'sd7);
      chk("bp_in_ready", {63'd0, in_ready}, 64'sd0);
      chk("bp_datta", {48'd0, datta}, 64'sd7);
      chk("bp_stm", {63'd0, stm}, 64'sd0);
    end
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    tick();
    chk("bp_rel_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("bp_rel_in_ready", {63'd0, in_ready}, 64'sd1);
    send(2, 16, 1'b0);

    // Reset in the middle of the MAC sweep
    do_reset();
    in_valid = 1'b1;
    in_data  = 16'd4;
    tick();
    nsent++;
    in_valid = 1'b0;
    in_data  = '0;
    for (int c = 2; c <= 6; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_in_ready", {63'd0, in_ready}, 64'sd1);
    chk("mr_out_valid", {63'd0, out_valid}, 64'sd0);
    chk("mr_tap_sel", {61'd0, tap_sel}, 64'sd0);
    chk("mr_y", 64'(y), 64'sd0);
    chk("mr_datta", {48'd0, datta}, 64'sd0);
    chk("mr_stm", {63'd0, stm}, 64'sd0);
    chk("mr_ldx", {63'd0, ldx}, 64'sd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      chk("mr_no_valid", {63'd0, out_valid}, 64'sd0);
    end
    send(5, 5, 1'b0);

    chk("strobe_overlap", 64'(overlap), 64'sd0);
    chk("stm_count", 64'(stm_cnt), 64'(nsent));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
